// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - AXI4 channel bundle between the fetch unit and memory
//
// Carries the AXI4 read address and read data channels used by ifu_prefetch,
// plus the write-channel strobes that the fetch unit ties off.
//   master : fetch unit side (drives AR, rready and the write tie-offs)
//   slave  : memory side (drives arready and the R channel)
interface ifu_prefetch_if #(
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic [2:0]        arsize;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              awvalid;
    logic              wvalid;
    logic              bready;

    modport master (
        output arvalid, araddr, arid, arlen, arburst, arsize, rready,
        output awvalid, wvalid, bready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arburst, arsize, rready,
        input  awvalid, wvalid, bready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with a credit-limited prefetch queue
//
// Issues sequential single-beat AXI4 reads from an internal fetch PC and
// buffers the returned words, tagged with their PC and a fault flag, in a
// DEPTH-entry FIFO feeding decode over a valid/ready handshake. A redirect
// flushes the queue, marks every stale read for discard and restarts fetch.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   redirect     single-cycle flush/restart request
//   redirect_pc  new fetch target (bits [1:0] ignored)
//   instF, pcF   head instruction and its PC (zero when the queue is empty)
//   faultF       head entry came back with a non-OKAY response
//   validF       queue head valid
//   readyD       decode accepts the head this cycle
//   axi          AXI4 read channels (master side)
module ifu_prefetch #(
    parameter int DEPTH    = 4,
    parameter     RESET_PC = 32'h8000_0000,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instF,
    output logic [ADDR_W-1:0] pcF,
    output logic              faultF,
    output logic              validF,
    input  logic              readyD,
    ifu_prefetch_if.master    axi
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_ALIGN = ~ADDR_W'(3);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [CW:0]       CREDITS  = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    // A request that was already on the bus when a redirect arrived: it must
    // keep its old address until accepted, so it lives in its own register.
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              flt_mem  [DEPTH];

    logic [CW:0]       used;
    logic              credit_ok;
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_fire;
    logic              ar_stall;
    logic              r_fire;
    logic              drop_beat;
    logic              push;
    logic              pop;

    always_comb begin
        used      = {1'b0, inflight_q} + {1'b0, count_q} + {{CW{1'b0}}, pend_q};
        credit_ok = used < CREDITS;
        ar_valid  = ~rst & (pend_q | credit_ok);
        ar_addr   = pend_q ? pend_addr_q : fetch_pc_q;
        ar_fire   = ar_valid & axi.arready;
        ar_stall  = ar_valid & ~axi.arready;
        r_fire    = axi.rvalid;
        drop_beat = r_fire & (drop_cnt_q != '0);
        push      = r_fire & ~drop_beat & ~redirect;
        pop       = validF & readyD & ~redirect;
    end

    assign axi.arvalid = ar_valid;
    assign axi.araddr  = ar_addr;
    assign axi.arid    = 4'd0;
    assign axi.arlen   = 8'd0;
    assign axi.arburst = 2'd0;
    assign axi.arsize  = 3'd2;
    assign axi.rready  = 1'b1;
    assign axi.awvalid = 1'b0;
    assign axi.wvalid  = 1'b0;
    assign axi.bready  = 1'b1;

    assign validF = (count_q != '0);
    assign instF  = validF ? inst_mem[rd_ptr_q] : 32'd0;
    assign pcF    = validF ? pc_mem[rd_ptr_q]   : '0;
    assign faultF = validF ? flt_mem[rd_ptr_q]  : 1'b0;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        inflight_d  = inflight_q;
        drop_cnt_d  = drop_cnt_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        if (ar_fire) inflight_d = inflight_d + CNT_ONE;
        if (r_fire)  inflight_d = inflight_d - CNT_ONE;

        if (redirect) begin
            fetch_pc_d = redirect_pc & PC_ALIGN;
            rsp_pc_d   = redirect_pc & PC_ALIGN;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still owed by the slave belongs to the old stream,
            // including a request stuck on the bus right now.
            drop_cnt_d = inflight_d + (ar_stall ? CNT_ONE : '0);
            pend_d     = ar_stall;
            if (ar_stall) pend_addr_d = ar_addr;
        end else begin
            if (ar_fire) begin
                if (pend_q) pend_d = 1'b0;
                else        fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (drop_beat) drop_cnt_d = drop_cnt_q - CNT_ONE;
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RST_PC;
            rsp_pc_q    <= RST_PC;
            inflight_q  <= '0;
            drop_cnt_q  <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            inflight_q  <= inflight_d;
            drop_cnt_q  <= drop_cnt_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= axi.rdata;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
            flt_mem[wr_ptr_q]  <= (axi.rresp != 2'b00);
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed self-checking bench for ifu_prefetch
module tb_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic        faultF;
    logic        validF;
    logic        readyD = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_prefetch_if #(.ADDR_W(32)) axi ();

    ifu_prefetch #(
        .DEPTH(4),
        .RESET_PC(32'h8000_0000),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instF(instF),
        .pcF(pcF),
        .faultF(faultF),
        .validF(validF),
        .readyD(readyD),
        .axi(axi)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Memory slave: in-order, each read returned lat cycles after its AR cycle.
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] fault_addr = 32'h8000_0008;
    logic [31:0] sq_addr[$];
    int          sq_due[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            sq_addr.delete();
            sq_due.delete();
            axi.rvalid <= 1'b0;
        end else begin
            if (axi.arvalid && axi.arready) begin
                sq_addr.push_back(axi.araddr);
                sq_due.push_back(cyc + lat - 1);
            end
            if (sq_addr.size() > 0 && sq_due[0] <= cyc) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= data_of(sq_addr[0]);
                axi.rresp  <= (sq_addr[0] == fault_addr) ? 2'b10 : 2'b00;
                void'(sq_addr.pop_front());
                void'(sq_due.pop_front());
            end else begin
                axi.rvalid <= 1'b0;
            end
        end
    end

    logic [31:0] ar_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic        pop_flt[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (axi.arvalid && axi.arready) ar_log.push_back(axi.araddr);
            if (validF && readyD) begin
                pop_pc.push_back(pcF);
                pop_inst.push_back(instF);
                pop_flt.push_back(faultF);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound && validF !== 1'b1; i++) @(negedge clk);
        check(tag, validF, 1);
    endtask

    int p0;
    int ia;
    int ip;

    initial begin
        axi.arready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_validF", validF, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_instF", instF, 0);
        check("rst_pcF", pcF, 0);
        check("rst_faultF", faultF, 0);
        check("rst_rready", axi.rready, 1);
        check("rst_arsize", axi.arsize, 2);

        // Sequential fetch, 1-cycle slave, decode always ready
        readyD = 1'b1;
        rst = 1'b0;
        #1;
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_araddr0", axi.araddr, 32'h8000_0000);
        check("t1_validF0", validF, 0);
        @(negedge clk);
        check("t1_araddr1", axi.araddr, 32'h8000_0004);
        check("t1_validF1", validF, 0);
        @(negedge clk);
        check("t1_validF2", validF, 1);
        check("t1_pcF2", pcF, 32'h8000_0000);
        check("t1_instF2", instF, 32'h0000_7FFF);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_pc%0d", i), pop_pc[i], 32'h8000_0000 + 32'(4 * i));
            check($sformatf("t1_inst%0d", i), pop_inst[i], data_of(32'h8000_0000 + 32'(4 * i)));
        end
        // Fault marking on the 0x80000008 read only
        check("t5_flt1", pop_flt[1], 0);
        check("t5_flt2", pop_flt[2], 1);
        check("t5_flt3", pop_flt[3], 0);

        // Decode stall: credits cap outstanding + buffered at 4
        readyD = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_arvalid", axi.arvalid, 0);
        check("t2_validF", validF, 1);
        check("t2_held", 32'(ar_log.size() - pop_pc.size()), 4);
        p0 = pop_pc.size();
        readyD = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_pc%0d", i), pop_pc[p0 + i], 32'h8000_0000 + 32'(4 * (p0 + i)));

        // Redirect with three reads in flight and one buffered entry
        axi.arready = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_drained", validF, 0);
        readyD = 1'b0;
        axi.arready = 1'b1;
        @(negedge clk);
        lat = 20;
        repeat (3) @(negedge clk);
        check("t3_arvalid_full", axi.arvalid, 0);
        check("t3_validF_pre", validF, 1);
        ip = pop_pc.size();
        redirect = 1'b1;
        redirect_pc = 32'h8000_1000;
        @(negedge clk);
        redirect = 1'b0;
        lat = 1;
        readyD = 1'b1;
        check("t3_validF_flush", validF, 0);
        check("t3_arvalid", axi.arvalid, 1);
        check("t3_araddr", axi.araddr, 32'h8000_1000);
        wait_valid("t3_wait_validF", 80);
        check("t3_pcF_first", pcF, 32'h8000_1000);
        check("t3_instF_first", instF, 32'h1000_7FFF);
        repeat (3) @(negedge clk);
        check("t3_pop0", pop_pc[ip], 32'h8000_1000);
        check("t3_pop1", pop_pc[ip + 1], 32'h8000_1004);

        // Redirect while an AR is stalled on the bus
        rst = 1'b1;
        axi.arready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi.arready = 1'b1;
        repeat (4) @(negedge clk);
        axi.arready = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_arvalid_pre", axi.arvalid, 1);
        check("t4_araddr_pre", axi.araddr, 32'h8000_0010);
        ia = ar_log.size();
        ip = pop_pc.size();
        redirect = 1'b1;
        redirect_pc = 32'h8000_2003;
        @(negedge clk);
        redirect = 1'b0;
        check("t4_arvalid_hold", axi.arvalid, 1);
        check("t4_araddr_hold", axi.araddr, 32'h8000_0010);
        check("t4_validF", validF, 0);
        repeat (2) @(negedge clk);
        check("t4_araddr_hold2", axi.araddr, 32'h8000_0010);
        axi.arready = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_ar0", ar_log[ia], 32'h8000_0010);
        check("t4_ar1", ar_log[ia + 1], 32'h8000_2000);
        check("t4_ar2", ar_log[ia + 2], 32'h8000_2004);
        check("t4_pop0", pop_pc[ip], 32'h8000_2000);
        check("t4_pop1", pop_pc[ip + 1], 32'h8000_2004);

        // Reset mid-operation
        readyD = 1'b0;
        lat = 6;
        repeat (3) @(negedge clk);
        check("t6_validF_pre", validF, 1);
        rst = 1'b1;
        #1;
        check("t6_validF_rst", validF, 0);
        check("t6_arvalid_rst", axi.arvalid, 0);
        check("t6_instF_rst", instF, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 1;
        readyD = 1'b1;
        #1;
        check("t6_arvalid", axi.arvalid, 1);
        check("t6_araddr", axi.araddr, 32'h8000_0000);
        ip = pop_pc.size();
        repeat (6) @(negedge clk);
        check("t6_pop0", pop_pc[ip], 32'h8000_0000);
        check("t6_pop1", pop_pc[ip + 1], 32'h8000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
